aig_sweep_misr: RTL and testbench

- Self-checking harness stage wrapped around a small ABC-synthesised AIG benchmark netlist (2 inputs, up to 32 outputs).
- Upstream side: drives every input pattern of the netlist in ascending binary order.
- Downstream side: compacts the netlist's output vector into a 32-bit MISR signature and compares it with a golden signature.
- Used to confirm that balanced/rewritten netlist variants stay functionally equivalent.

---
 rtl/aig_bench_pkg.sv | 29 ++
 rtl/misr_compactor.sv | 30 +++
 rtl/aig_sweep_misr.sv | 109 ++++++++++
 tb/tb_aig_sweep_misr.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/aig_bench_pkg.sv
// Shared types and constants for the AIG benchmark harness stages.
package aig_bench_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam int unsigned MISR_W = 32;

    localparam logic [MISR_W-1:0] DEF_POLY = 32'h04C1_1DB7;
    localparam logic [MISR_W-1:0] DEF_SEED = 32'h0000_0000;

    // One MISR step: shift left, fold the polynomial back in on carry-out, absorb data.
    function automatic logic [MISR_W-1:0] misr_step(
        input logic [MISR_W-1:0] sig,
        input logic [MISR_W-1:0] poly,
        input logic [MISR_W-1:0] data
    );
        logic [MISR_W-1:0] shifted;
        shifted = {sig[MISR_W-2:0], 1'b0};
        if (sig[MISR_W-1]) begin
            shifted = shifted ^ poly;
        end
        return shifted ^ data;
    endfunction

endpackage

// File: rtl/misr_compactor.sv
// 32-bit multiple-input signature register; reusable by any harness stage.
module misr_compactor
    import aig_bench_pkg::*;
#(
    parameter logic [MISR_W-1:0] POLY = DEF_POLY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic [MISR_W-1:0] seed,
    input  logic [MISR_W-1:0] data_i,
    output logic [MISR_W-1:0] sig_o
);

    logic [MISR_W-1:0] sig_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= seed;
        end else if (load) begin
            sig_q <= seed;
        end else if (en) begin
            sig_q <= misr_step(sig_q, POLY, data_i);
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/aig_sweep_misr.sv
// Exhaustive input sweep of a small netlist with MISR compaction of its responses.
module aig_sweep_misr
    import aig_bench_pkg::*;
#(
    parameter int unsigned       N_IN          = 2,
    parameter int unsigned       N_OUT         = 18,
    parameter int unsigned       SETTLE_CYCLES = 1,
    parameter logic [MISR_W-1:0] MISR_POLY     = DEF_POLY,
    parameter logic [MISR_W-1:0] MISR_SEED     = DEF_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MISR_W-1:0] golden_sig,
    output logic [N_IN-1:0]   pat_o,
    input  logic [N_OUT-1:0]  resp_i,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] sig_o
);

    localparam int unsigned   SW          = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    state_e            state_q, state_d;
    logic [N_IN-1:0]   pat_q, pat_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic              pass_q, pass_d;
    logic              load, step;
    logic [MISR_W-1:0] resp_ext;
    logic [MISR_W-1:0] sig_next;

    assign resp_ext = MISR_W'(resp_i);
    // Signature as it will be after this edge's step, so pass can be decided on the same edge.
    assign sig_next = misr_step(sig_o, MISR_POLY, resp_ext);

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        settle_d = settle_q;
        pass_d   = pass_q;
        load     = 1'b0;
        step     = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StRun;
                    pat_d    = '0;
                    settle_d = '0;
                    pass_d   = 1'b0;
                    load     = 1'b1;
                end
            end
            StRun: begin
                if (settle_q == SETTLE_LAST) begin
                    step     = 1'b1;
                    settle_d = '0;
                    if (&pat_q) begin
                        state_d = StDone;
                        pass_d  = (sig_next == golden_sig);
                    end else begin
                        pat_d = pat_q + 1'b1;
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            pat_q    <= '0;
            settle_q <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            settle_q <= settle_d;
            pass_q   <= pass_d;
        end
    end

    misr_compactor #(
        .POLY (MISR_POLY)
    ) u_misr (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .en     (step),
        .seed   (MISR_SEED),
        .data_i (resp_ext),
        .sig_o  (sig_o)
    );

    assign pat_o = pat_q;
    assign busy  = (state_q == StRun);
    assign done  = (state_q == StDone);
    assign pass  = pass_q;

endmodule

// File: tb/tb_aig_sweep_misr.sv
// Directed and randomized sweeps of aig_sweep_misr against a truth-table signature model.
module tb_aig_sweep_misr;

    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with single-cycle settle
    logic        rst, start;
    logic [31:0] golden;
    logic [1:0]  pat;
    logic [17:0] resp;
    logic        busy, done, pass;
    logic [31:0] sig;
    logic [17:0] tt [4];

    // Instance with three-cycle settle
    logic        rst3, start3;
    logic [31:0] golden3;
    logic [1:0]  pat3;
    logic [17:0] resp3;
    logic        busy3, done3, pass3;
    logic [31:0] sig3;
    logic [17:0] tt3 [4];

    int checks = 0;
    int errors = 0;

    logic [1:0] pq  [$];
    logic [1:0] pq3 [$];

    assign resp = tt[pat];

    aig_sweep_misr #(
        .N_IN(2), .N_OUT(18), .SETTLE_CYCLES(1), .MISR_POLY(POLY), .MISR_SEED(32'h0)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .golden_sig(golden), .pat_o(pat),
        .resp_i(resp), .busy(busy), .done(done), .pass(pass), .sig_o(sig)
    );

    aig_sweep_misr #(
        .N_IN(2), .N_OUT(18), .SETTLE_CYCLES(3), .MISR_POLY(POLY), .MISR_SEED(32'h0)
    ) u_dut3 (
        .clk(clk), .rst(rst3), .start(start3), .golden_sig(golden3), .pat_o(pat3),
        .resp_i(resp3), .busy(busy3), .done(done3), .pass(pass3), .sig_o(sig3)
    );

    // Netlist stand-in for the slow instance: random glitches except in the final hold cycle.
    logic       glitch = 1'b0;
    int         hc = 0;
    logic [1:0] prev3 = 2'd0;
    always @(negedge clk) begin
        if (pat3 !== prev3) hc = 0;
        else hc = hc + 1;
        prev3 = pat3;
        resp3 = (glitch && hc < 2) ? 18'($urandom) : tt3[pat3];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Signature of one full sweep: patterns 0..3 in order, each response absorbed once.
    function automatic logic [31:0] model(input logic [17:0] t [4]);
        logic [31:0] s = 32'h0;
        for (int p = 0; p < 4; p++) begin
            s = ((s << 1) ^ (s[31] ? POLY : 32'h0)) ^ {14'h0, t[p]};
        end
        return s;
    endfunction

    task automatic sweep1(input logic [31:0] g, output int lat);
        golden = g;
        pq.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) pq.push_back(pat);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic sweep3(input logic [31:0] g, output int lat);
        golden3 = g;
        pq3.delete();
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
        lat = 0;
        while (done3 !== 1'b1 && lat < 200) begin
            if (busy3 === 1'b1) pq3.push_back(pat3);
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] exp;
        logic        bad;
        logic        seen;

        rst = 1'b1; start = 1'b0; golden = '0;
        rst3 = 1'b1; start3 = 1'b0; golden3 = '0;
        for (int p = 0; p < 4; p++) begin
            tt[p] = '0;
            tt3[p] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_pass", {31'h0, pass}, 32'h0);
        chk("rst_sig", sig, 32'h0);
        chk("rst_pat", {30'h0, pat}, 32'h0);
        chk("rst3_busy", {31'h0, busy3}, 32'h0);
        rst = 1'b0; rst3 = 1'b0;

        // All-zero response
        sweep1(32'h0, lat);
        chk("zero_lat", lat, 4);
        chk("zero_sig", sig, 32'h0);
        chk("zero_pass", {31'h0, pass}, 32'h1);

        // Single hit at the first pattern, matching and mismatching golden
        tt[0] = 18'h1;
        sweep1(32'h8, lat);
        chk("first_sig", sig, 32'h8);
        chk("first_pass", {31'h0, pass}, 32'h1);
        sweep1(32'h9, lat);
        chk("first_sig2", sig, 32'h8);
        chk("first_fail_pass", {31'h0, pass}, 32'h0);

        // Single hit at the last pattern, plus the observed pattern order
        tt[0] = 18'h0; tt[3] = 18'h1;
        sweep1(32'h1, lat);
        chk("last_sig", sig, 32'h1);
        chk("last_pass", {31'h0, pass}, 32'h1);
        chk("seq_len", pq.size(), 4);
        for (int i = 0; i < 4 && i < pq.size(); i++) chk("seq_pat", {30'h0, pq[i]}, i);

        // Values hold after completion; a start during DONE is ignored
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("done_start_busy", {31'h0, busy}, 32'h0);
        repeat (3) @(negedge clk);
        chk("hold_sig", sig, 32'h1);
        chk("hold_pass", {31'h0, pass}, 32'h1);
        chk("hold_pat", {30'h0, pat}, 32'h3);
        chk("hold_done", {31'h0, done}, 32'h0);

        // Randomized truth tables
        for (int n = 0; n < 6; n++) begin
            for (int p = 0; p < 4; p++) tt[p] = 18'($urandom);
            exp = model(tt);
            bad = 1'($urandom_range(0, 1));
            sweep1(bad ? (exp ^ (32'h1 << $urandom_range(0, 31))) : exp, lat);
            chk("rnd_lat", lat, 4);
            chk("rnd_sig", sig, exp);
            chk("rnd_pass", {31'h0, pass}, {31'h0, ~bad});
        end

        // Three-cycle settle with glitching responses
        glitch = 1'b1;
        for (int n = 0; n < 2; n++) begin
            for (int p = 0; p < 4; p++) tt3[p] = 18'($urandom);
            exp = model(tt3);
            sweep3(exp, lat);
            chk("settle_lat", lat, 12);
            chk("settle_sig", sig3, exp);
            chk("settle_pass", {31'h0, pass3}, 32'h1);
            chk("settle_len", pq3.size(), 12);
            for (int i = 0; i < 12 && i < pq3.size(); i++)
                chk("settle_pat", {30'h0, pq3[i]}, i / 3);
        end
        glitch = 1'b0;

        // Reset during the second pattern aborts without a done pulse
        for (int p = 0; p < 4; p++) tt[p] = 18'($urandom) | 18'h1;
        golden = 32'h0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        chk("abort_pat1", {30'h0, pat}, 32'h1);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_pat", {30'h0, pat}, 32'h0);
        chk("abort_sig", sig, 32'h0);
        seen = done;
        repeat (6) begin
            @(negedge clk);
            seen = seen | done;
        end
        chk("abort_nodone", {31'h0, seen}, 32'h0);
        exp = model(tt);
        sweep1(exp, lat);
        chk("after_abort_lat", lat, 4);
        chk("after_abort_sig", sig, exp);
        chk("after_abort_pass", {31'h0, pass}, 32'h1);

        // A second start while running does not restart the sweep
        pq.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            start = (lat == 2);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("busy_start_lat", lat, 4);
        chk("busy_start_sig", sig, exp);

        // Reset wins over a simultaneous start
        @(negedge clk) begin rst = 1'b1; start = 1'b1; end
        @(negedge clk) begin rst = 1'b0; start = 1'b0; end
        chk("rst_start_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        chk("rst_start_busy2", {31'h0, busy}, 32'h0);
        chk("rst_start_pass", {31'h0, pass}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
